// File: rtl/avalon_register_bridge.sv
`default_nettype none
// =============================================================================
// Module   : avalon_register_bridge
// Function : Avalon-style command FIFO + credit-limited issue + response FIFO
// Revision : 1.0
// =============================================================================
module avalon_register_bridge #(
  parameter int BUSWIDTH     = 32,
  parameter int ADDRESSWIDTH = 4,
  parameter int LATENCY      = 1,
  parameter int CMD_DEPTH    = 4,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic [ADDRESSWIDTH-1:0] s_address,
  input  logic [BUSWIDTH-1:0]     s_writedata,
  output logic                    s_waitrequest,
  output logic [BUSWIDTH-1:0]     s_readdata,
  output logic                    s_readdatavalid,
  input  logic                    s_rsp_ready,
  output logic                    m_read,
  output logic                    m_write,
  output logic [ADDRESSWIDTH-1:0] m_address,
  output logic [BUSWIDTH-1:0]     m_data_in,
  input  logic                    m_read_valid,
  input  logic [BUSWIDTH-1:0]     m_data_out,
  input  logic                    err_clear,
  output logic                    err_overflow,
  output logic                    err_unexpected,
  output logic                    err_both
);

  localparam int c_cmd_aw = $clog2(CMD_DEPTH);
  localparam int c_rsp_aw = $clog2(RSP_DEPTH);
  localparam int c_cmd_w  = 1 + ADDRESSWIDTH + BUSWIDTH;
  localparam logic [c_cmd_aw:0] c_cmd_full = (c_cmd_aw + 1)'(CMD_DEPTH);
  localparam logic [c_rsp_aw:0] c_rsp_full = (c_rsp_aw + 1)'(RSP_DEPTH);

  if (LATENCY < 1 || CMD_DEPTH < 2 || RSP_DEPTH < 2 ||
      (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_param
    $error("avalon_register_bridge: illegal parameter set");
  end

  logic [c_cmd_w-1:0]      cmd_mem_q [CMD_DEPTH];
  logic [c_cmd_aw-1:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [c_cmd_aw:0]       cmd_cnt_q, cmd_cnt_d;
  logic [BUSWIDTH-1:0]     rsp_mem_q [RSP_DEPTH];
  logic [c_rsp_aw-1:0]     rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [c_rsp_aw:0]       rsp_cnt_q, rsp_cnt_d;
  logic [c_rsp_aw:0]       outstanding_q, outstanding_d;
  logic                    waitreq_q, waitreq_d;
  logic                    m_read_q, m_read_d, m_write_q, m_write_d;
  logic [ADDRESSWIDTH-1:0] m_address_q, m_address_d;
  logic [BUSWIDTH-1:0]     m_data_q, m_data_d;
  logic                    err_ovf_q, err_ovf_d, err_unx_q, err_unx_d, err_both_q, err_both_d;

  logic [c_cmd_w-1:0] w_head;
  logic               w_head_write, w_accept, w_credit, w_issue;
  logic               w_ret_ok, w_rsp_push, w_rsp_pop;

  assign w_head       = cmd_mem_q[cmd_rd_q];
  assign w_head_write = w_head[c_cmd_w-1];
  assign w_accept     = (s_read | s_write) & ~waitreq_q;
  // A read may only issue if its response is guaranteed a slot in the response FIFO.
  assign w_credit     = ({1'b0, outstanding_q} + {1'b0, rsp_cnt_q}) < {1'b0, c_rsp_full};
  assign w_issue      = (cmd_cnt_q != '0) & (w_head_write | w_credit);
  assign w_ret_ok     = m_read_valid & (outstanding_q != '0);
  assign w_rsp_push   = w_ret_ok & (rsp_cnt_q != c_rsp_full);
  assign w_rsp_pop    = (rsp_cnt_q != '0) & s_rsp_ready;

  always_comb begin
    cmd_wr_d      = cmd_wr_q + c_cmd_aw'(w_accept);
    cmd_rd_d      = cmd_rd_q + c_cmd_aw'(w_issue);
    cmd_cnt_d     = cmd_cnt_q + (c_cmd_aw + 1)'(w_accept) - (c_cmd_aw + 1)'(w_issue);
    waitreq_d     = (cmd_cnt_d == c_cmd_full);
    m_read_d      = w_issue & ~w_head_write;
    m_write_d     = w_issue & w_head_write;
    m_address_d   = m_address_q;
    m_data_d      = m_data_q;
    if (w_issue) begin
      m_address_d = w_head[BUSWIDTH +: ADDRESSWIDTH];
      m_data_d    = w_head[BUSWIDTH-1:0];
    end
    outstanding_d = outstanding_q + (c_rsp_aw + 1)'(m_read_d) - (c_rsp_aw + 1)'(w_ret_ok);
    rsp_wr_d      = rsp_wr_q + c_rsp_aw'(w_rsp_push);
    rsp_rd_d      = rsp_rd_q + c_rsp_aw'(w_rsp_pop);
    rsp_cnt_d     = rsp_cnt_q + (c_rsp_aw + 1)'(w_rsp_push) - (c_rsp_aw + 1)'(w_rsp_pop);
    err_both_d    = (err_both_q & ~err_clear) | (w_accept & s_read & s_write);
    err_unx_d     = (err_unx_q & ~err_clear) | (m_read_valid & (outstanding_q == '0));
    err_ovf_d     = (err_ovf_q & ~err_clear) | (w_ret_ok & (rsp_cnt_q == c_rsp_full));
  end

  always_ff @(posedge clk) begin
    if (w_accept)   cmd_mem_q[cmd_wr_q] <= {s_write, s_address, s_writedata};
    if (w_rsp_push) rsp_mem_q[rsp_wr_q] <= m_data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_wr_q      <= '0;
      cmd_rd_q      <= '0;
      cmd_cnt_q     <= '0;
      rsp_wr_q      <= '0;
      rsp_rd_q      <= '0;
      rsp_cnt_q     <= '0;
      outstanding_q <= '0;
      waitreq_q     <= 1'b1;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_data_q      <= '0;
      err_ovf_q     <= 1'b0;
      err_unx_q     <= 1'b0;
      err_both_q    <= 1'b0;
    end else begin
      cmd_wr_q      <= cmd_wr_d;
      cmd_rd_q      <= cmd_rd_d;
      cmd_cnt_q     <= cmd_cnt_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_cnt_q     <= rsp_cnt_d;
      outstanding_q <= outstanding_d;
      waitreq_q     <= waitreq_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_data_q      <= m_data_d;
      err_ovf_q     <= err_ovf_d;
      err_unx_q     <= err_unx_d;
      err_both_q    <= err_both_d;
    end
  end

  assign s_waitrequest   = waitreq_q;
  assign s_readdatavalid = (rsp_cnt_q != '0);
  assign s_readdata      = (rsp_cnt_q != '0) ? rsp_mem_q[rsp_rd_q] : '0;
  assign m_read          = m_read_q;
  assign m_write         = m_write_q;
  assign m_address       = m_address_q;
  assign m_data_in       = m_data_q;
  assign err_overflow    = err_ovf_q;
  assign err_unexpected  = err_unx_q;
  assign err_both        = err_both_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_register_bridge.sv
`default_nettype none
// =============================================================================
// Module   : tb_avalon_register_bridge
// Function : randomized + directed bench with a queue-based reference model
// Revision : 1.0
// =============================================================================
module tb_avalon_register_bridge;

  localparam int BW    = 32;
  localparam int AW    = 4;
  localparam int CMD_D = 4;
  localparam int RSP_D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_read = 1'b0, s_write = 1'b0;
  logic [AW-1:0] s_address = '0;
  logic [BW-1:0] s_writedata = '0;
  logic          s_waitrequest, s_readdatavalid;
  logic [BW-1:0] s_readdata;
  logic          s_rsp_ready = 1'b0;
  logic          m_read, m_write;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_data_in;
  logic          m_read_valid = 1'b0;
  logic [BW-1:0] m_data_out = '0;
  logic          err_clear = 1'b0;
  logic          err_overflow, err_unexpected, err_both;

  always #5 clk = ~clk;

  avalon_register_bridge #(
    .BUSWIDTH(BW), .ADDRESSWIDTH(AW), .LATENCY(1), .CMD_DEPTH(CMD_D), .RSP_DEPTH(RSP_D)
  ) dut (
    .clk(clk), .reset(reset),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_rsp_ready(s_rsp_ready),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_data_in(m_data_in),
    .m_read_valid(m_read_valid), .m_data_out(m_data_out),
    .err_clear(err_clear), .err_overflow(err_overflow), .err_unexpected(err_unexpected),
    .err_both(err_both)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: command queue, response queue, outstanding-read count.
  typedef struct { bit w; logic [AW-1:0] a; logic [BW-1:0] d; } cmd_t;
  cmd_t          cq[$];
  logic [BW-1:0] rq[$];
  int            outst = 0;
  bit            e_wait = 1'b1, e_mr = 1'b0, e_mw = 1'b0;
  bit            e_eo = 1'b0, e_eu = 1'b0, e_eb = 1'b0;
  logic [AW-1:0] e_ma = '0;
  logic [BW-1:0] e_md = '0;

  task automatic model_reset();
    cq.delete(); rq.delete(); outst = 0;
    e_wait = 1'b1; e_mr = 1'b0; e_mw = 1'b0; e_ma = '0; e_md = '0;
    e_eo = 1'b0; e_eu = 1'b0; e_eb = 1'b0;
  endtask

  task automatic model_step();
    bit   acc, iss, full, pop;
    cmd_t h;
    acc = (s_read || s_write) && !e_wait;
    h.w = 1'b0; h.a = '0; h.d = '0;
    iss = 1'b0;
    if (cq.size() > 0) begin
      h = cq[0];
      iss = h.w || (outst + rq.size() < RSP_D);
    end
    e_mr = iss && !h.w;
    e_mw = iss && h.w;
    if (iss) begin
      e_ma = h.a;
      e_md = h.d;
      void'(cq.pop_front());
    end
    if (acc) cq.push_back('{w: s_write, a: s_address, d: s_writedata});
    e_wait = (cq.size() == CMD_D);
    full = (rq.size() == RSP_D);
    pop  = (rq.size() > 0) && s_rsp_ready;
    if (pop) void'(rq.pop_front());
    if (err_clear) begin e_eo = 1'b0; e_eu = 1'b0; e_eb = 1'b0; end
    if (acc && s_read && s_write) e_eb = 1'b1;
    if (m_read_valid) begin
      if (outst == 0) e_eu = 1'b1;
      else begin
        if (full) e_eo = 1'b1;
        else rq.push_back(m_data_out);
        outst--;
      end
    end
    if (e_mr) outst++;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("s_waitrequest", s_waitrequest, e_wait);
    chk("s_readdatavalid", s_readdatavalid, rq.size() > 0);
    if (rq.size() > 0) chk("s_readdata", s_readdata, rq[0]);
    chk("m_read", m_read, e_mr);
    chk("m_write", m_write, e_mw);
    chk("m_address", m_address, e_ma);
    chk("m_data_in", m_data_in, e_md);
    chk("err_overflow", err_overflow, e_eo);
    chk("err_unexpected", err_unexpected, e_eu);
    chk("err_both", err_both, e_eb);
  end

  // Register adapter: returns each read at least one cycle after its strobe.
  int pend = 0;
  bit rand_mode = 1'b0;
  bit inject = 1'b0;
  bit vld;
  initial forever begin
    @(posedge clk);
    #3;
    vld = (pend > 0) && (!rand_mode || $urandom_range(3) != 0);
    if (rand_mode && $urandom_range(59) == 0) vld = 1'b1;
    if (inject) vld = 1'b1;
    m_read_valid = vld;
    m_data_out   = $urandom;
    if (vld && pend > 0) pend--;
    if (m_read === 1'b1) pend++;
  end

  int mr_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (m_read === 1'b1) mr_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit r, input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d);
    bit ok;
    ok = 1'b0;
    s_read = r; s_write = w; s_address = a; s_writedata = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_waitrequest === 1'b0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("send accepted", ok, 1'b1);
    cyc();
    s_read = 1'b0; s_write = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst s_waitrequest", s_waitrequest, 1'b1);
    chk("rst m_read", m_read, 1'b0);
    chk("rst m_write", m_write, 1'b0);
    chk("rst m_address", m_address, 0);
    chk("rst m_data_in", m_data_in, 0);
    chk("rst s_readdata", s_readdata, 0);
    chk("rst s_readdatavalid", s_readdatavalid, 1'b0);
    chk("rst errors", {err_overflow, err_unexpected, err_both}, 3'b000);
  endtask

  int base;

  initial begin
    repeat (3) cyc();
    @(negedge clk);
    check_reset_values();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("waitreq before first edge", s_waitrequest, 1'b1);
    cyc();
    @(negedge clk);
    chk("waitreq after release", s_waitrequest, 1'b0);

    // Single write: strobe exactly two cycles after acceptance.
    cyc();
    s_write = 1'b1; s_address = 4'd3; s_writedata = 32'hA5A5_A5A5;
    cyc();
    s_write = 1'b0;
    @(negedge clk);
    chk("wr N+1 m_write", m_write, 1'b0);
    cyc();
    @(negedge clk);
    chk("wr N+2 m_write", m_write, 1'b1);
    chk("wr N+2 m_address", m_address, 4'd3);
    chk("wr N+2 m_data_in", m_data_in, 32'hA5A5_A5A5);
    cyc();
    @(negedge clk);
    chk("wr N+3 m_write", m_write, 1'b0);
    chk("wr N+3 m_data_in hold", m_data_in, 32'hA5A5_A5A5);

    // Read and write together: a single write, err_both.
    cyc();
    s_read = 1'b1; s_write = 1'b1; s_address = 4'd2; s_writedata = 32'h0000_1234;
    cyc();
    s_read = 1'b0; s_write = 1'b0;
    @(negedge clk);
    chk("both err_both", err_both, 1'b1);
    cyc();
    @(negedge clk);
    chk("both m_write", m_write, 1'b1);
    chk("both m_read", m_read, 1'b0);
    chk("both m_address", m_address, 4'd2);
    cyc();
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0;
    @(negedge clk);
    chk("err_both cleared", err_both, 1'b0);

    // Unexpected read return.
    cyc();
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    @(negedge clk);
    chk("unexpected set", err_unexpected, 1'b1);
    chk("unexpected no push", s_readdatavalid, 1'b0);
    cyc();
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0;
    @(negedge clk);
    chk("unexpected cleared", err_unexpected, 1'b0);

    // Five reads against a 4-entry response FIFO that is not drained.
    cyc();
    s_rsp_ready = 1'b0;
    base = mr_cnt;
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, AW'(i + 4), '0);
    repeat (20) cyc();
    @(negedge clk);
    chk("credit limits to 4 reads", mr_cnt - base, 4);
    chk("responses waiting", s_readdatavalid, 1'b1);
    cyc();
    s_rsp_ready = 1'b1;
    cyc();
    s_rsp_ready = 1'b0;
    repeat (10) cyc();
    @(negedge clk);
    chk("fifth read after pop", mr_cnt - base, 5);
    cyc();
    s_rsp_ready = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    chk("responses drained", s_readdatavalid, 1'b0);

    // Randomized traffic, including occasional resets and stray returns.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset       = ($urandom_range(499) == 0);
      s_read      = ($urandom_range(2) == 0);
      s_write     = ($urandom_range(2) == 0);
      s_address   = AW'($urandom);
      s_writedata = $urandom;
      s_rsp_ready = (i < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      err_clear   = ($urandom_range(39) == 0);
    end
    cyc();
    reset = 1'b0; s_read = 1'b0; s_write = 1'b0; err_clear = 1'b0;
    rand_mode = 1'b0; s_rsp_ready = 1'b1;
    repeat (30) cyc();

    // Reset with commands queued behind a credit-blocked read.
    s_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, AW'(i), '0);
    send(1'b0, 1'b1, 4'd9, 32'hDEAD_BEEF);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("final waitreq held", s_waitrequest, 1'b1);
    cyc();
    @(negedge clk);
    chk("final waitreq released", s_waitrequest, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
